// File: rtl/matrix_input_collector.sv
// matrix_input_collector: byte-stream to packed matrix bus.
// Receives rows, cols, then elements in row-major order.
module matrix_input_collector #(
    parameter int DIM_MAX = 5,
    parameter int DATA_W  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              abort,
    output logic [$clog2(DIM_MAX+1)-1:0]      m_out,
    output logic [$clog2(DIM_MAX+1)-1:0]      n_out,
    output logic [DIM_MAX*DIM_MAX*DATA_W-1:0] matrix,
    output logic                              out_valid,
    input  logic                              out_ack,
    output logic                              error
);

    localparam int CW = $clog2(DIM_MAX + 1);
    localparam int IW = $clog2(DIM_MAX * DIM_MAX);
    localparam int BW = $clog2(DIM_MAX * DIM_MAX * DATA_W);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        S_M,
        S_N,
        S_E,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] idx;
    logic [BW-1:0] base;
    logic          accept;
    logic          dim_ok;
    logic          col_last;
    logic          last;
    logic          store_m;
    logic          store_n;
    logic          reject;
    logic          reject_n;
    logic          clear;
    logic          write;

    assign in_ready  = (state != S_DONE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign dim_ok    = (in_data != '0) && (in_data <= DATA_W'(DIM_MAX));
    assign col_last  = (col == n_out - ONE);
    assign last      = col_last && (row == m_out - ONE);
    assign idx       = IW'(row) * IW'(DIM_MAX) + IW'(col);
    assign base      = BW'(idx) * BW'(DATA_W);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_M;
        end else begin
            state <= next;
        end
    end

    // Next state and per-cycle datapath strobes; abort beats the byte.
    always_comb begin
        next     = state;
        store_m  = 1'b0;
        store_n  = 1'b0;
        reject   = 1'b0;
        reject_n = 1'b0;
        clear    = 1'b0;
        write    = 1'b0;
        unique case (state)
            S_M: begin
                if (accept) begin
                    if (dim_ok) begin
                        store_m = 1'b1;
                        next    = S_N;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_N: begin
                if (abort) begin
                    clear = 1'b1;
                    next  = S_M;
                end else if (accept) begin
                    if (dim_ok) begin
                        store_n = 1'b1;
                        next    = S_E;
                    end else begin
                        reject   = 1'b1;
                        reject_n = 1'b1;
                        next     = S_M;
                    end
                end
            end
            S_E: begin
                if (abort) begin
                    clear = 1'b1;
                    next  = S_M;
                end else if (accept) begin
                    write = 1'b1;
                    if (last) begin
                        next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ack) begin
                    next = S_M;
                end
            end
            default: next = S_M;
        endcase
    end

    // Dimensions, element bus, position counters and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            matrix <= '0;
            m_out  <= '0;
            n_out  <= '0;
            row    <= '0;
            col    <= '0;
            error  <= 1'b0;
        end else begin
            error <= reject;
            if (clear) begin
                matrix <= '0;
                m_out  <= '0;
                n_out  <= '0;
            end
            if (store_m) begin
                m_out  <= in_data[CW-1:0];
                matrix <= '0;
            end
            if (reject_n) begin
                m_out <= '0;
            end
            if (store_n) begin
                n_out <= in_data[CW-1:0];
                row   <= '0;
                col   <= '0;
            end
            if (write) begin
                matrix[base +: DATA_W] <= in_data;
                if (col_last) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_collector.sv
// tb_matrix_input_collector: scenario tasks plus randomized
// loads checked against a row-major queue model.
module tb_matrix_input_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         abort;
    logic [2:0]   m_out;
    logic [2:0]   n_out;
    logic [199:0] matrix;
    logic         out_valid;
    logic         out_ack;
    logic         error;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];

    matrix_input_collector dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .abort    (abort),
        .m_out    (m_out),
        .n_out    (n_out),
        .matrix   (matrix),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Expected bus: queue holds the m x n elements in row-major order.
    function automatic logic [199:0] model_bus(input int m, input int n);
        logic [199:0] b;
        b = '0;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                b[(r*5+c)*8 +: 8] = q[r*n+c];
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({out_valid, in_ready, error, m_out, n_out} !== 9'b010_000_000) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 010000000",
                     {out_valid, in_ready, error, m_out, n_out});
        end
        total++;
        if (matrix !== '0) begin
            bad++;
            $display("FAIL reset_matrix: got %h want 0", matrix);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[5] = '{1, 3, 1, 2, 3};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
            total++;
            if (out_valid !== (i == 4)) begin
                bad++;
                $display("FAIL basic_valid[%0d]: got %b want %b", i, out_valid, i == 4);
            end
        end
        // keep presenting a byte: it must not be taken in S_DONE
        in_data = 8'hEE;
        tick();
        in_valid = 1'b0;
        total++;
        if ({m_out, n_out, in_ready, out_valid} !== 8'b001_011_0_1) begin
            bad++;
            $display("FAIL basic_dims: got %b want 00101101",
                     {m_out, n_out, in_ready, out_valid});
        end
        total++;
        if (matrix !== 200'h03_02_01) begin
            bad++;
            $display("FAIL basic_matrix: got %h want 030201", matrix);
        end
        ack();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL basic_ack: got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_toggle_5x5();
        xfer(5);
        tick();
        xfer(5);
        tick();
        q = {};
        for (int i = 0; i < 25; i++) begin
            q.push_back(8'(i));
            xfer(8'(i));
            total++;
            if (out_valid !== (i == 24)) begin
                bad++;
                $display("FAIL tog_valid[%0d]: got %b want %b", i, out_valid, i == 24);
            end
            if (i < 24) tick();
        end
        total++;
        if (matrix !== model_bus(5, 5)) begin
            bad++;
            $display("FAIL tog_matrix: got %h want %h", matrix, model_bus(5, 5));
        end
        ack();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tog_ack: got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_errors();
        xfer(0);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL err_m0: got %b want 1", error);
        end
        xfer(6);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL err_m6: got %b want 1", error);
        end
        tick();
        total++;
        if ({error, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL err_clear: got %b want 01", {error, in_ready});
        end
        xfer(2);
        xfer(7);
        total++;
        if ({error, m_out} !== 4'b1_000) begin
            bad++;
            $display("FAIL err_n7: got %b want 1000", {error, m_out});
        end
        tick();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL err_n7_pulse: got %b want 0", error);
        end
        q = '{9, 8, 7, 6};
        xfer(2);
        xfer(2);
        foreach (q[i]) xfer(q[i]);
        total++;
        if ({out_valid, m_out, n_out} !== 7'b1_010_010) begin
            bad++;
            $display("FAIL err_dims: got %b want 1010010", {out_valid, m_out, n_out});
        end
        total++;
        if (matrix !== model_bus(2, 2)) begin
            bad++;
            $display("FAIL err_matrix: got %h want %h", matrix, model_bus(2, 2));
        end
        ack();
    endtask

    task automatic test_abort();
        xfer(3);
        xfer(3);
        xfer(1);
        xfer(2);
        in_valid = 1'b1;
        in_data  = 8'd4;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        total++;
        if ({error, m_out, n_out, in_ready} !== 8'b0_000_000_1) begin
            bad++;
            $display("FAIL abort_ctl: got %b want 00000001",
                     {error, m_out, n_out, in_ready});
        end
        total++;
        if (matrix !== '0) begin
            bad++;
            $display("FAIL abort_matrix: got %h want 0", matrix);
        end
        xfer(1);
        xfer(1);
        xfer(42);
        total++;
        if ({out_valid, matrix} !== {1'b1, 200'd42}) begin
            bad++;
            $display("FAIL abort_reload: got %b/%h want 1/2a", out_valid, matrix);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({out_valid, matrix} !== {1'b1, 200'd42}) begin
            bad++;
            $display("FAIL abort_done: got %b/%h want 1/2a", out_valid, matrix);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        xfer(4);
        xfer(4);
        for (int i = 0; i < 6; i++) xfer(8'(i + 10));
        reset    = 1'b1;
        out_ack  = 1'b1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        tick();
        reset    = 1'b0;
        out_ack  = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, m_out, n_out} !== 8'b01_000_000) begin
            bad++;
            $display("FAIL rstmid_ctl: got %b want 01000000",
                     {out_valid, in_ready, m_out, n_out});
        end
        total++;
        if (matrix !== '0) begin
            bad++;
            $display("FAIL rstmid_matrix: got %h want 0", matrix);
        end
    endtask

    task automatic test_back_to_back();
        q = '{11, 12, 13, 14};
        xfer(2);
        xfer(2);
        foreach (q[i]) xfer(q[i]);
        ack();
        tick();
        total++;
        if ({matrix, m_out, n_out} !== {model_bus(2, 2), 6'b010_010}) begin
            bad++;
            $display("FAIL hold_after_ack: got %h want %h", matrix, model_bus(2, 2));
        end
        xfer(0);
        total++;
        if (matrix !== model_bus(2, 2)) begin
            bad++;
            $display("FAIL hold_after_bad: got %h want %h", matrix, model_bus(2, 2));
        end
        xfer(1);
        total++;
        if ({matrix, m_out} !== {200'd0, 3'd1}) begin
            bad++;
            $display("FAIL hold_clear: got %h/%0d want 0/1", matrix, m_out);
        end
        xfer(1);
        xfer(5);
        total++;
        if ({out_valid, matrix} !== {1'b1, 200'd5}) begin
            bad++;
            $display("FAIL hold_second: got %b/%h want 1/5", out_valid, matrix);
        end
        ack();
    endtask

    task automatic test_random();
        int m;
        int n;
        for (int it = 0; it < 25; it++) begin
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                xfer(8'($urandom_range(6, 255)));
                total++;
                if (error !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_err[%0d]: got %b want 1", it, error);
                end
            end
            q = {};
            for (int i = 0; i < m * n; i++) q.push_back(8'($urandom));
            xfer(8'(m));
            xfer(8'(n));
            for (int i = 0; i < m * n; i++) begin
                while ($urandom_range(0, 2) == 0) tick();
                xfer(q[i]);
                if (i < m * n - 1 && out_valid !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_early[%0d]: got 1 want 0 at %0d", it, i);
                end
            end
            in_valid = 1'b1;
            in_data  = 8'hA5;
            tick();
            tick();
            in_valid = 1'b0;
            total++;
            if ({out_valid, in_ready, m_out, n_out} !== {2'b10, 3'(m), 3'(n)}) begin
                bad++;
                $display("FAIL rnd_ctl[%0d]: got %b want %b", it,
                         {out_valid, in_ready, m_out, n_out}, {2'b10, 3'(m), 3'(n)});
            end
            total++;
            if (matrix !== model_bus(m, n)) begin
                bad++;
                $display("FAIL rnd_matrix[%0d]: got %h want %h", it, matrix, model_bus(m, n));
            end
            ack();
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        out_ack  = 1'b0;
        test_reset();
        test_basic();
        test_toggle_5x5();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
